// File: rtl/decode_pipe_if.sv
// Handshake bundle between fetch, the decode_pipe stage and execute.
// slave = the decode stage, master = its environment (fetch + execute).
`ifndef CPU_WIDTH
`define CPU_WIDTH 32
`endif

interface decode_pipe_if #(
  parameter int PC_WIDTH = `CPU_WIDTH
) ();
  // fetch side
  logic                   inst_valid_i;
  logic                   inst_ready_o;
  logic [`CPU_WIDTH-1:0]  inst_i;
  logic [PC_WIDTH-1:0]    pc_i;
  // execute side
  logic                   dec_valid_o;
  logic                   dec_ready_i;
  logic [PC_WIDTH-1:0]    dec_pc_o;
  logic [`CPU_WIDTH-1:0]  dec_inst_o;
  logic                   branch_o;
  logic [1:0]             jump_o;
  logic                   reg_wr_en_o;
  logic [4:0]             reg_wr_adder_o;
  logic [4:0]             reg1_rd_adder_o;
  logic [4:0]             reg2_rd_adder_o;
  logic [2:0]             imm_gen_op_o;
  logic                   csr_wr_en_o;
  logic [11:0]            csr_wr_adder_o;
  logic [11:0]            csr_rd_adder_o;
  logic [4:0]             alu_op_o;
  logic [1:0]             alu_src_sel_o;
  logic [1:0]             alu_res_op_o;
  logic                   illegal_o;

  modport slave (
    input  inst_valid_i, inst_i, pc_i, dec_ready_i,
    output inst_ready_o, dec_valid_o, dec_pc_o, dec_inst_o,
           branch_o, jump_o, reg_wr_en_o, reg_wr_adder_o, reg1_rd_adder_o,
           reg2_rd_adder_o, imm_gen_op_o, csr_wr_en_o, csr_wr_adder_o,
           csr_rd_adder_o, alu_op_o, alu_src_sel_o, alu_res_op_o, illegal_o
  );

  modport master (
    output inst_valid_i, inst_i, pc_i, dec_ready_i,
    input  inst_ready_o, dec_valid_o, dec_pc_o, dec_inst_o,
           branch_o, jump_o, reg_wr_en_o, reg_wr_adder_o, reg1_rd_adder_o,
           reg2_rd_adder_o, imm_gen_op_o, csr_wr_en_o, csr_wr_adder_o,
           csr_rd_adder_o, alu_op_o, alu_src_sel_o, alu_res_op_o, illegal_o
  );
endinterface

// File: rtl/decode_pipe.sv
// Queued, registered RV32I decode stage with flush and illegal-instruction flagging.
// Define DECODE_MEXT_EN to decode the M extension; otherwise funct7=0x01 R-type is illegal.
`ifndef CPU_WIDTH
`define CPU_WIDTH 32
`endif

module decode_pipe #(
  parameter int DEPTH    = 4,
  parameter int PC_WIDTH = `CPU_WIDTH
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush_i,
  decode_pipe_if.slave               bus,
  output logic [$clog2(DEPTH+1)-1:0] occupancy_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [2:0] F3_ADD_SUB = 3'd0;
  localparam logic [2:0] F3_SLL     = 3'd1;
  localparam logic [2:0] F3_SRL_SRA = 3'd5;

  localparam logic [1:0] JUMP_JAL   = 2'd1;
  localparam logic [1:0] JUMP_JALR  = 2'd2;
  localparam logic [1:0] JUMP_FENCE = 2'd3;

  localparam logic [2:0] IMM_GEN_I    = 3'd0;
  localparam logic [2:0] IMM_GEN_S    = 3'd1;
  localparam logic [2:0] IMM_GEN_B    = 3'd2;
  localparam logic [2:0] IMM_GEN_U    = 3'd3;
  localparam logic [2:0] IMM_GEN_J    = 3'd4;
  localparam logic [2:0] IMM_GEN_CSR  = 3'd5;
  localparam logic [2:0] IMM_GEN_NONE = 3'd7;

  localparam logic [4:0] ALU_ADD  = 5'd0;
  localparam logic [4:0] ALU_SUB  = 5'd1;
  localparam logic [4:0] ALU_SLL  = 5'd2;
  localparam logic [4:0] ALU_SLT  = 5'd3;
  localparam logic [4:0] ALU_SLTU = 5'd4;
  localparam logic [4:0] ALU_XOR  = 5'd5;
  localparam logic [4:0] ALU_SRL  = 5'd6;
  localparam logic [4:0] ALU_SRA  = 5'd7;
  localparam logic [4:0] ALU_OR   = 5'd8;
  localparam logic [4:0] ALU_AND  = 5'd9;
  localparam logic [4:0] ALU_BEQ  = 5'd10;
  localparam logic [4:0] ALU_BNE  = 5'd11;
  localparam logic [4:0] ALU_BLT  = 5'd12;
  localparam logic [4:0] ALU_BGE  = 5'd13;
  localparam logic [4:0] ALU_BLTU = 5'd14;
  localparam logic [4:0] ALU_BGEU = 5'd15;
`ifdef DECODE_MEXT_EN
  localparam logic [4:0] ALU_MUL  = 5'd16;  // MUL..REMU follow in funct3 order
`endif

  localparam logic [1:0] SRC_REG    = 2'd0;
  localparam logic [1:0] SRC_IMM    = 2'd1;
  localparam logic [1:0] SRC_PC_IMM = 2'd2;
  localparam logic [1:0] SRC_PC_4   = 2'd3;

  localparam logic [1:0] RES_ALU  = 2'd0;
  localparam logic [1:0] RES_MEM  = 2'd1;
  localparam logic [1:0] RES_CSR  = 2'd2;
  localparam logic [1:0] RES_NONE = 2'd3;

  typedef struct packed {
    logic        branch;
    logic [1:0]  jump;
    logic        reg_wr_en;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  imm_op;
    logic        csr_wr_en;
    logic [11:0] csr_wr;
    logic [11:0] csr_rd;
    logic [4:0]  alu_op;
    logic [1:0]  alu_src;
    logic [1:0]  alu_res;
    logic        illegal;
  } ctrl_t;

  localparam ctrl_t CTRL_NULL = '{imm_op: IMM_GEN_NONE, alu_res: RES_NONE, default: '0};

  function automatic logic [4:0] alu_base(input logic [2:0] f3);
    case (f3)
      3'd0:    return ALU_ADD;
      3'd1:    return ALU_SLL;
      3'd2:    return ALU_SLT;
      3'd3:    return ALU_SLTU;
      3'd4:    return ALU_XOR;
      3'd5:    return ALU_SRL;
      3'd6:    return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

  function automatic ctrl_t decode(input logic [31:0] inst);
    ctrl_t      c;
    logic [2:0] f3;
    logic [6:0] f7;
    f3 = inst[14:12];
    f7 = inst[31:25];
    c  = CTRL_NULL;
    case (inst[6:0])
      OP_REG: begin
        c.reg_wr_en = 1'b1;
        c.rd        = inst[11:7];
        c.rs1       = inst[19:15];
        c.rs2       = inst[24:20];
        c.alu_src   = SRC_REG;
        c.alu_res   = RES_ALU;
        case (f7)
          7'h00: c.alu_op = alu_base(f3);
          7'h20: begin
            if (f3 == F3_ADD_SUB)      c.alu_op  = ALU_SUB;
            else if (f3 == F3_SRL_SRA) c.alu_op  = ALU_SRA;
            else                       c.illegal = 1'b1;
          end
`ifdef DECODE_MEXT_EN
          7'h01: c.alu_op = ALU_MUL + {2'b00, f3};
`endif
          default: c.illegal = 1'b1;
        endcase
      end
      OP_IMM: begin
        c.reg_wr_en = 1'b1;
        c.rd        = inst[11:7];
        c.rs1       = inst[19:15];
        c.imm_op    = IMM_GEN_I;
        c.alu_src   = SRC_IMM;
        c.alu_res   = RES_ALU;
        c.alu_op    = alu_base(f3);
        if (f3 == F3_SLL && f7 != 7'h00) c.illegal = 1'b1;
        if (f3 == F3_SRL_SRA) begin
          if (f7 == 7'h20)      c.alu_op  = ALU_SRA;
          else if (f7 != 7'h00) c.illegal = 1'b1;
        end
      end
      OP_LOAD: begin
        c.reg_wr_en = 1'b1;
        c.rd        = inst[11:7];
        c.rs1       = inst[19:15];
        c.imm_op    = IMM_GEN_I;
        c.alu_src   = SRC_IMM;
        c.alu_op    = ALU_ADD;
        c.alu_res   = RES_MEM;
      end
      OP_STORE: begin
        c.rs1     = inst[19:15];
        c.rs2     = inst[24:20];
        c.imm_op  = IMM_GEN_S;
        c.alu_src = SRC_IMM;
        c.alu_op  = ALU_ADD;
      end
      OP_BRANCH: begin
        c.branch = 1'b1;
        c.rs1    = inst[19:15];
        c.rs2    = inst[24:20];
        c.imm_op = IMM_GEN_B;
        case (f3)
          3'd0:    c.alu_op  = ALU_BEQ;
          3'd1:    c.alu_op  = ALU_BNE;
          3'd4:    c.alu_op  = ALU_BLT;
          3'd5:    c.alu_op  = ALU_BGE;
          3'd6:    c.alu_op  = ALU_BLTU;
          3'd7:    c.alu_op  = ALU_BGEU;
          default: c.illegal = 1'b1;
        endcase
      end
      OP_JAL: begin
        c.jump      = JUMP_JAL;
        c.reg_wr_en = 1'b1;
        c.rd        = inst[11:7];
        c.imm_op    = IMM_GEN_J;
        c.alu_src   = SRC_PC_4;
        c.alu_res   = RES_ALU;
      end
      OP_JALR: begin
        c.jump      = JUMP_JALR;
        c.reg_wr_en = 1'b1;
        c.rd        = inst[11:7];
        c.rs1       = inst[19:15];
        c.imm_op    = IMM_GEN_I;
        c.alu_src   = SRC_PC_4;
        c.alu_res   = RES_ALU;
        c.illegal   = (f3 != 3'd0);
      end
      OP_LUI, OP_AUIPC: begin
        c.reg_wr_en = 1'b1;
        c.rd        = inst[11:7];
        c.imm_op    = IMM_GEN_U;
        c.alu_src   = (inst[6:0] == OP_LUI) ? SRC_IMM : SRC_PC_IMM;
        c.alu_res   = RES_ALU;
      end
      OP_FENCE: c.jump = JUMP_FENCE;
      OP_SYSTEM: begin
        // Execute combines the old CSR value with rs1/zimm using alu_op.
        c.csr_wr_en = 1'b1;
        c.csr_wr    = inst[31:20];
        c.csr_rd    = inst[31:20];
        c.reg_wr_en = 1'b1;
        c.rd        = inst[11:7];
        c.rs1       = f3[2] ? 5'd0 : inst[19:15];
        c.imm_op    = f3[2] ? IMM_GEN_CSR : IMM_GEN_NONE;
        c.alu_src   = f3[2] ? SRC_IMM : SRC_REG;
        c.alu_res   = RES_CSR;
        c.alu_op    = (f3[1:0] == 2'b10) ? ALU_OR : (f3[1:0] == 2'b11) ? ALU_AND : ALU_ADD;
        c.illegal   = (f3 == 3'd0);
      end
      default: c.illegal = 1'b1;
    endcase
    if (c.illegal) begin
      c         = CTRL_NULL;
      c.illegal = 1'b1;
    end
    return c;
  endfunction

  logic [`CPU_WIDTH-1:0] inst_mem [DEPTH];
  logic [PC_WIDTH-1:0]   pc_mem   [DEPTH];

  logic [PW-1:0]         rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  dec_valid_q, dec_valid_d;
  ctrl_t                 ctrl_q, ctrl_d;
  logic [PC_WIDTH-1:0]   dec_pc_q, dec_pc_d;
  logic [`CPU_WIDTH-1:0] dec_inst_q, dec_inst_d;

  logic                  push, load, head_sel, bypass, enq;
  logic [`CPU_WIDTH-1:0] src_inst;
  logic [PC_WIDTH-1:0]   src_pc;

  // inst_ready_o looks only at the registered count, never at dec_ready_i.
  assign bus.inst_ready_o = rst_n && (count_q < FULL);

  // NOTE: every always_comb output gets a value before any branch, so no latch can form.
  always_comb begin
    push     = bus.inst_valid_i && bus.inst_ready_o;
    load     = !dec_valid_q || bus.dec_ready_i;
    head_sel = load && (count_q != '0);
    bypass   = load && (count_q == '0) && push;
    enq      = push && !bypass;
    src_inst = head_sel ? inst_mem[rd_ptr_q] : bus.inst_i;
    src_pc   = head_sel ? pc_mem[rd_ptr_q]   : bus.pc_i;

    wr_ptr_d    = enq      ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d    = head_sel ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d     = count_q + CW'(enq) - CW'(head_sel);
    dec_valid_d = load ? (head_sel || bypass) : dec_valid_q;
    ctrl_d      = ctrl_q;
    dec_pc_d    = dec_pc_q;
    dec_inst_d  = dec_inst_q;
    if (head_sel || bypass) begin
      ctrl_d     = decode(src_inst);
      dec_pc_d   = src_pc;
      dec_inst_d = src_inst;
    end
  end

  // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n || flush_i) begin
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      dec_valid_q <= 1'b0;
      ctrl_q      <= CTRL_NULL;
      dec_pc_q    <= '0;
      dec_inst_q  <= '0;
    end else begin
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      dec_valid_q <= dec_valid_d;
      ctrl_q      <= ctrl_d;
      dec_pc_q    <= dec_pc_d;
      dec_inst_q  <= dec_inst_d;
    end
  end

  // NOTE: queue storage is deliberately not reset; an entry is only read after it is written.
  always_ff @(posedge clk) begin
    if (enq) begin
      inst_mem[wr_ptr_q] <= bus.inst_i;
      pc_mem[wr_ptr_q]   <= bus.pc_i;
    end
  end

  assign occupancy_o         = count_q;
  assign bus.dec_valid_o     = dec_valid_q;
  assign bus.dec_pc_o        = dec_pc_q;
  assign bus.dec_inst_o      = dec_inst_q;
  assign bus.branch_o        = ctrl_q.branch;
  assign bus.jump_o          = ctrl_q.jump;
  assign bus.reg_wr_en_o     = ctrl_q.reg_wr_en;
  assign bus.reg_wr_adder_o  = ctrl_q.rd;
  assign bus.reg1_rd_adder_o = ctrl_q.rs1;
  assign bus.reg2_rd_adder_o = ctrl_q.rs2;
  assign bus.imm_gen_op_o    = ctrl_q.imm_op;
  assign bus.csr_wr_en_o     = ctrl_q.csr_wr_en;
  assign bus.csr_wr_adder_o  = ctrl_q.csr_wr;
  assign bus.csr_rd_adder_o  = ctrl_q.csr_rd;
  assign bus.alu_op_o        = ctrl_q.alu_op;
  assign bus.alu_src_sel_o   = ctrl_q.alu_src;
  assign bus.alu_res_op_o    = ctrl_q.alu_res;
  assign bus.illegal_o       = ctrl_q.illegal;
endmodule

// File: doc/decode_pipe.md
# decode_pipe

Registered, flow-controlled decode stage that replaces the purely combinational decoder between fetch and execute. Fetched instructions, each paired with its PC, enter a DEPTH-entry instruction queue. The head is decoded into the standard control bundle and held in an output register with a valid/ready handshake. It adds flush support, illegal-instruction flagging and compile-time M-extension gating.

## Interface
- DEPTH, 4, instruction queue entries; power of two, ≥2
- PC_WIDTH, `CPU_WIDTH, PC width carried with each instruction
- clk  in  1  core clock, all state updates on rising edge
- rst_n  in  1  synchronous active-low reset, sampled on rising edge of clk
- flush_i  in  1  discard queue and output register (branch/jump/trap redirect)
- inst_valid_i  in  1  fetch presents an instruction
- inst_ready_o  out  1  queue can accept; high when occupancy < DEPTH
- inst_i  in  `CPU_WIDTH  instruction word
- pc_i  in  PC_WIDTH  PC of inst_i
- dec_valid_o  out  1  output register holds a decoded instruction
- dec_ready_i  in  1  execute accepts the output register this cycle
- dec_pc_o  out  PC_WIDTH; dec_inst_o  out  `CPU_WIDTH  PC and raw word of the held instruction
- branch_o, jump_o, reg_wr_en_o, reg_wr_adder_o, reg1_rd_adder_o, reg2_rd_adder_o, imm_gen_op_o, csr_wr_en_o, csr_wr_adder_o, csr_rd_adder_o, alu_op_o, alu_src_sel_o, alu_res_op_o  out  standard `rooth_defines.v` widths  registered decoded control bundle, same encodings as the core decoder
- illegal_o  out  1  held instruction is illegal
- occupancy_o  out  $clog2(DEPTH+1)  queue entries in use, excluding the output register

## Operation
- Queue: circular buffer with rd_ptr, wr_ptr and count. Push when inst_valid_i && inst_ready_o. Pointers wrap modulo DEPTH.
- Output register load: when !dec_valid_o || dec_ready_i. Load source is the queue head if count>0. Otherwise the input is loaded directly (bypass) if it is pushing this cycle. When bypass is used, the input does not enter the queue.
- Pop from the queue only when the head is loaded. Push and pop in the same cycle leave count unchanged.
- Decode is combinational on the selected source and is registered with it. dec_valid_o deasserts after a handshake if nothing is available to load.
- Illegal: unknown opcode; R-type funct7 not in {0x00, 0x20, 0x01}; 0x20 used with funct3 other than ADD_SUB/SRL_SRA; SLLI imm[11:5]≠0; SRLI/SRAI imm[11:5] not in {0x00, 0x20}; JALR funct3≠0; CSR funct3=0; B-type funct3 2 or 3.
  - Illegal instructions set illegal_o=1. All control outputs take null defaults (reg_wr_en_o=0, csr_wr_en_o=0, imm_gen_op_o=3'b111, alu_res_op_o=2'b11). dec_pc_o and dec_inst_o stay valid for trap handling.
- FENCE: jump_o=`JUMP_FENCE`, all other controls null, legal.
- Flush: highest priority. Next cycle count=0, pointers=0, dec_valid_o=0. Any push or handshake in the flush cycle is discarded.

## Timing
- Latency: input to dec_valid_o is 1 cycle when queue is empty and the output register is free or draining; otherwise FIFO order plus one cycle per older entry.
- Throughput: 1 instruction/cycle sustained with dec_ready_i=1.
- inst_ready_o depends only on registered count. It has no combinational path from dec_ready_i, so no push is accepted when full even if a pop occurs that cycle.
- Decoded outputs are stable while dec_valid_o && !dec_ready_i.
- Reset (rst_n=0 at an edge), applied mid-operation: everything is discarded.
  - Zero: count, pointers, dec_valid_o, illegal_o, branch_o, jump_o, register/CSR addresses, enables, alu_op_o, alu_src_sel_o, dec_pc_o, dec_inst_o, occupancy_o.
  - Null: imm_gen_op_o=3'b111, alu_res_op_o=2'b11.
  - inst_ready_o=0 while rst_n is low; it goes to 1 on the first cycle after release.

## Configuration
- DECODE_MEXT_EN defined: funct7=0x01 R-type decodes to ALU_MUL…ALU_REMU by funct3.
- DECODE_MEXT_EN undefined: funct7=0x01 R-type is illegal (illegal_o=1, null controls). No multiply/divide encodings are ever emitted.

## Test plan
- Reset then single push of 0x00500093 (addi x1,x0,5) at PC 0x100 with dec_ready_i=1. Next cycle: dec_valid_o=1, reg_wr_adder_o=1, alu_op_o=ALU_ADD, imm_gen_op_o=IMM_GEN_I, dec_pc_o=0x100.
- Hold dec_ready_i=0 and push DEPTH+1 instructions (DEPTH=4). Required: 1 in the output register, occupancy_o=4, inst_ready_o=0. On releasing dec_ready_i, the 5 instructions emerge in order on consecutive cycles.
- Full queue, push attempted in the same cycle as a pop: push is rejected and occupancy_o goes 4→3.
- Flush asserted with 3 queued plus a concurrent push: next cycle dec_valid_o=0, occupancy_o=0. The next push reappears after 1 cycle.
- 0x02208033 (mul) with DECODE_MEXT_EN gives alu_op_o=ALU_MUL, illegal_o=0. Without the macro: illegal_o=1, reg_wr_en_o=0.
- 0xFFFFFFFF (bad opcode), 0x0000100F (fence.i-class FENCE opcode) and 0x00001067 (JALR funct3=1) give illegal_o=1, jump_o=JUMP_FENCE with illegal_o=0, and illegal_o=1 respectively.
